// File: rtl/core_pkg.sv
// Core-side types for the instruction fetch request/response interface
// between core_s1 and the instruction responder.
package core_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } mmu_instr_req_s;

    typedef struct packed {
        logic        ready;
        logic [31:0] instr;
        logic        illegal;
    } mmu_instr_rsp_s;

endpackage

// File: rtl/mmu_instr_responder.sv
// Instruction fetch responder: bare physical addressing, one single-word bus read per fetch.
// Optional one-entry fetch buffer enabled by `define LETC_MMU_INSTR_FETCH_BUF_EN.
module mmu_instr_responder
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'hDEADBEEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  mmu_instr_req_s mmu_instr_req,
    output mmu_instr_rsp_s mmu_instr_rsp,
    input  logic           fencei,
    output logic           mem_req_valid,
    output logic [31:0]    mem_req_addr,
    input  logic           mem_req_ready,
    input  logic           mem_rsp_valid,
    input  logic [31:0]    mem_rsp_data,
    input  logic           mem_rsp_err
);

    typedef enum logic [1:0] {IDLE, BUSREQ, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        ready_q, ready_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instr_q, instr_d;
    logic        mem_req_valid_q, mem_req_valid_d;
    logic [31:0] mem_req_addr_q, mem_req_addr_d;

    logic        accept;
    logic        abort;
    logic        buf_hit;
    logic        buf_fill;
    logic [31:0] buf_data;

    assign accept = (state_q == IDLE) && mmu_instr_req.valid && !ready_q;
    // A flush or redirect shows up as the core dropping valid or changing the address.
    assign abort  = !mmu_instr_req.valid || (mmu_instr_req.addr != req_addr_q);

`ifdef LETC_MMU_INSTR_FETCH_BUF_EN
    logic        buf_valid_q;
    logic [29:0] buf_word_q;
    logic [31:0] buf_data_q;

    assign buf_hit  = buf_valid_q && (buf_word_q == mmu_instr_req.addr[31:2]);
    assign buf_data = buf_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
        end else if (fencei) begin
            buf_valid_q <= 1'b0;
        end else if (buf_fill) begin
            buf_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_fill) begin
            buf_word_q <= req_addr_q[31:2];
            buf_data_q <= mem_rsp_data;
        end
    end
`else
    logic unused_fencei;

    assign buf_hit       = 1'b0;
    assign buf_data      = '0;
    assign unused_fencei = fencei ^ buf_fill;
`endif

    always_comb begin
        state_d         = state_q;
        drop_d          = drop_q;
        req_addr_d      = req_addr_q;
        ready_d         = 1'b0;
        illegal_d       = 1'b0;
        instr_d         = RESET_INSTR;
        mem_req_valid_d = 1'b0;
        mem_req_addr_d  = mem_req_addr_q;
        buf_fill        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_addr_d = mmu_instr_req.addr;
                    drop_d     = 1'b0;
                    if (mmu_instr_req.addr[1:0] != 2'b00) begin
                        state_d   = RESP;
                        ready_d   = 1'b1;
                        illegal_d = 1'b1;
                        instr_d   = '0;
                    end else if (buf_hit) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        instr_d = buf_data;
                    end else begin
                        state_d         = BUSREQ;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {mmu_instr_req.addr[31:2], 2'b00};
                    end
                end
            end
            BUSREQ: begin
                if (abort) drop_d = 1'b1;
                // The request stays up until the bus takes it, even when aborted.
                if (mem_req_valid_q && mem_req_ready) begin
                    state_d = WAIT;
                end else begin
                    mem_req_valid_d = 1'b1;
                end
            end
            WAIT: begin
                if (abort) drop_d = 1'b1;
                if (mem_rsp_valid) begin
                    buf_fill = !mem_rsp_err;
                    if (drop_q) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d   = RESP;
                        ready_d   = 1'b1;
                        instr_d   = mem_rsp_data;
                        illegal_d = mem_rsp_err;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            drop_q          <= 1'b0;
            req_addr_q      <= '0;
            ready_q         <= 1'b0;
            illegal_q       <= 1'b0;
            instr_q         <= RESET_INSTR;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            state_q         <= state_d;
            drop_q          <= drop_d;
            req_addr_q      <= req_addr_d;
            ready_q         <= ready_d;
            illegal_q       <= illegal_d;
            instr_q         <= instr_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
        end
    end

    assign mmu_instr_rsp.ready   = ready_q;
    assign mmu_instr_rsp.instr   = instr_q;
    assign mmu_instr_rsp.illegal = illegal_q;
    assign mem_req_valid         = mem_req_valid_q;
    assign mem_req_addr          = mem_req_addr_q;

endmodule

// File: tb/tb_mmu_instr_responder.sv
// Randomized self-checking bench for mmu_instr_responder against a fetch-level reference model
// and a behavioural bus responder.
module tb_mmu_instr_responder;
    import core_pkg::*;

`ifdef LETC_MMU_INSTR_FETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif
    localparam logic [31:0] RESET_INSTR = 32'hDEADBEEF;

    logic           clk = 1'b0;
    logic           rst_n;
    mmu_instr_req_s req;
    mmu_instr_rsp_s rsp;
    logic           fencei;
    logic           mem_req_valid;
    logic [31:0]    mem_req_addr;
    logic           mem_req_ready;
    logic           mem_rsp_valid;
    logic [31:0]    mem_rsp_data;
    logic           mem_rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural bus: stall cycles before accepting, then response after rsp_lat idle cycles.
    int          stall_left = 0;
    int          rsp_lat    = 0;
    int          pend_cnt   = 0;
    int          req_count  = 0;
    bit          pend       = 0;
    bit          err_cfg    = 0;
    bit          ovr_en     = 0;
    logic [31:0] ovr_data   = '0;
    logic [31:0] pend_addr  = '0;
    logic [31:0] last_req_addr = '0;

    // Reference fetch-buffer contents.
    bit          m_buf_valid = 0;
    logic [29:0] m_buf_word  = '0;
    logic [31:0] m_buf_data  = '0;

    int          lat, nreq, e_lat, e_nreq;
    logic [31:0] ins, raddr, ins_a, e_ins;
    logic        ill, rdy_a, ill_a, e_ill;

    mmu_instr_responder #(.RESET_INSTR(RESET_INSTR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mmu_instr_req (req),
        .mmu_instr_rsp (rsp),
        .fencei        (fencei),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0011_8093;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic step();
        bit          hs;
        logic [31:0] hs_addr;
        hs      = mem_req_valid && mem_req_ready;
        hs_addr = mem_req_addr;
        @(posedge clk);
        #1;
        if (hs && rst_n) begin
            req_count++;
            last_req_addr = hs_addr;
            pend          = 1;
            pend_cnt      = rsp_lat;
            pend_addr     = hs_addr;
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_data  = $urandom;
        if (pend) begin
            if (pend_cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_err   = err_cfg;
                mem_rsp_data  = ovr_en ? ovr_data : mem_word(pend_addr);
                pend          = 0;
            end else begin
                pend_cnt--;
            end
        end
        mem_req_ready = (stall_left == 0);
        if (mem_req_valid && stall_left > 0) stall_left--;
    endtask

    // Spec-level expectation for one fetch; updates the reference buffer.
    task automatic model_fetch(input logic [31:0] a, input int stall, input int rl, input bit err);
        if (a[1:0] != 2'b00) begin
            e_lat = 1; e_ins = '0; e_ill = 1'b1; e_nreq = 0;
        end else if (BUF_EN && m_buf_valid && m_buf_word == a[31:2]) begin
            e_lat = 1; e_ins = m_buf_data; e_ill = 1'b0; e_nreq = 0;
        end else begin
            e_lat  = 3 + stall + rl;
            e_ins  = ovr_en ? ovr_data : mem_word({a[31:2], 2'b00});
            e_ill  = err;
            e_nreq = 1;
            if (BUF_EN && !err) begin
                m_buf_valid = 1; m_buf_word = a[31:2]; m_buf_data = e_ins;
            end
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input int stall, input int rl, input bit err);
        int start;
        bit got;
        stall_left = stall; rsp_lat = rl; err_cfg = err;
        start = req_count;
        req.valid = 1'b1; req.addr = a;
        lat = -1; ins = '0; ill = 1'b0; got = 0;
        for (int i = 1; i <= 60 && !got; i++) begin
            step();
            if (rsp.ready) begin
                got = 1; lat = i; ins = rsp.instr; ill = rsp.illegal;
                req.valid = 1'b0;
            end
        end
        req.valid = 1'b0;
        step();
        rdy_a = rsp.ready; ins_a = rsp.instr; ill_a = rsp.illegal;
        nreq  = req_count - start;
        raddr = last_req_addr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_checks++; if (rsp.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", rsp.ready); end
        n_checks++; if (rsp.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", rsp.illegal); end
        n_checks++; if (rsp.instr !== RESET_INSTR) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", rsp.instr, RESET_INSTR); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
        n_checks++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_req_addr: got %h expected 0", mem_req_addr); end
        rst_n = 1'b1;
        m_buf_valid = 0;
        step();
    endtask

    task automatic test_misaligned();
        model_fetch(32'h0000_0102, 0, 0, 0);
        do_fetch(32'h0000_0102, 0, 0, 0);
        n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL misaligned_latency: got %0d expected %0d", lat, e_lat); end
        n_checks++; if (ill !== 1'b1 || ins !== 32'h0) begin n_fail++; $display("FAIL misaligned_rsp: got ill=%b instr=%h expected ill=1 instr=0", ill, ins); end
        n_checks++; if (nreq !== 0) begin n_fail++; $display("FAIL misaligned_bus: got %0d requests expected 0", nreq); end
        n_checks++; if (ins_a !== RESET_INSTR || ill_a !== 1'b0) begin n_fail++; $display("FAIL misaligned_revert: got instr=%h ill=%b expected %h 0", ins_a, ill_a, RESET_INSTR); end
    endtask

    task automatic test_aligned_miss();
        model_fetch(32'h100, 0, 0, 0);
        do_fetch(32'h100, 0, 0, 0);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL miss_latency: got %0d expected 3", lat); end
        n_checks++; if (ins !== 32'h0011_8093 || ill !== 1'b0) begin n_fail++; $display("FAIL miss_rsp: got %h ill=%b expected 00118093 ill=0", ins, ill); end
        n_checks++; if (nreq !== 1 || raddr !== 32'h100) begin n_fail++; $display("FAIL miss_bus: got %0d reqs addr %h expected 1 at 100", nreq, raddr); end
        n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_width: ready after pulse %b expected 0", rdy_a); end
    endtask

    task automatic test_buffer();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                fencei = 1'b1; step(); fencei = 1'b0;
                m_buf_valid = 0;
            end
            model_fetch(32'h100, 0, 0, 0);
            do_fetch(32'h100, 0, 0, 0);
            n_checks++; if (lat !== e_lat || nreq !== e_nreq) begin n_fail++; $display("FAIL buffer_fetch%0d: got lat=%0d reqs=%0d expected lat=%0d reqs=%0d", k, lat, nreq, e_lat, e_nreq); end
            n_checks++; if (ins !== e_ins) begin n_fail++; $display("FAIL buffer_data%0d: got %h expected %h", k, ins, e_ins); end
        end
    endtask

    task automatic test_spurious();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_5555; mem_rsp_err = 1'b0;
        step();
        n_checks++; if (rsp.ready !== 1'b0) begin n_fail++; $display("FAIL spurious_ready: got %b expected 0", rsp.ready); end
        step();
        model_fetch(32'h100, 0, 0, 0);
        do_fetch(32'h100, 0, 0, 0);
        n_checks++; if (ins !== e_ins || lat !== e_lat) begin n_fail++; $display("FAIL spurious_after: got %h lat=%0d expected %h lat=%0d", ins, lat, e_ins, e_lat); end
    endtask

    task automatic test_backpressure();
        int  start;
        bit  got;
        bit  stable;
        model_fetch(32'h404, 5, 0, 0);
        stall_left = 5; rsp_lat = 0; err_cfg = 0; start = req_count;
        req.valid = 1'b1; req.addr = 32'h404;
        step();
        stable = 1;
        for (int i = 0; i < 6; i++) begin
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h404) stable = 0;
            step();
        end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL backpressure_stable: request not held, now valid=%b addr=%h", mem_req_valid, mem_req_addr); end
        got = 0; lat = -1;
        for (int i = 8; i <= 40 && !got; i++) begin
            if (rsp.ready) begin got = 1; lat = i - 1; ins = rsp.instr; req.valid = 1'b0; end
            else step();
        end
        req.valid = 1'b0;
        step(); step();
        n_checks++; if (lat !== e_lat || ins !== e_ins) begin n_fail++; $display("FAIL backpressure_rsp: got lat=%0d %h expected lat=%0d %h", lat, ins, e_lat, e_ins); end
        n_checks++; if (req_count - start !== 1) begin n_fail++; $display("FAIL backpressure_count: got %0d requests expected 1", req_count - start); end
    endtask

    task automatic test_abort();
        int start;
        int pulses;
        start = req_count;
        ovr_en = 1; ovr_data = 32'hDEAD_0000;
        stall_left = 0; rsp_lat = 3; err_cfg = 0;
        req.valid = 1'b1; req.addr = 32'h180;
        step(); step();
        req.valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp.ready) pulses++;
        end
        ovr_en = 0;
        if (BUF_EN) begin m_buf_valid = 1; m_buf_word = 30'h180 >> 2; m_buf_data = 32'hDEAD_0000; end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses); end
        n_checks++; if (req_count - start !== 1) begin n_fail++; $display("FAIL abort_bus: got %0d requests expected 1", req_count - start); end
        model_fetch(32'h200, 0, 0, 0);
        do_fetch(32'h200, 0, 0, 0);
        n_checks++; if (nreq !== 1 || raddr !== 32'h200) begin n_fail++; $display("FAIL abort_refetch_bus: got %0d reqs addr %h expected 1 at 200", nreq, raddr); end
        n_checks++; if (ins !== e_ins || lat !== e_lat) begin n_fail++; $display("FAIL abort_refetch_rsp: got %h lat=%0d expected %h lat=%0d", ins, lat, e_ins, e_lat); end
    endtask

    task automatic test_bus_error();
        model_fetch(32'h300, 1, 1, 1);
        do_fetch(32'h300, 1, 1, 1);
        n_checks++; if (ill !== 1'b1 || ins !== e_ins || lat !== e_lat) begin n_fail++; $display("FAIL buserr_rsp: got ill=%b %h lat=%0d expected ill=1 %h lat=%0d", ill, ins, lat, e_ins, e_lat); end
        model_fetch(32'h300, 0, 0, 0);
        do_fetch(32'h300, 0, 0, 0);
        n_checks++; if (nreq !== 1 || ill !== 1'b0) begin n_fail++; $display("FAIL buserr_refetch: got %0d reqs ill=%b expected 1 reqs ill=0", nreq, ill); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        stall_left = 0; rsp_lat = 4; err_cfg = 0;
        req.valid = 1'b1; req.addr = 32'h500;
        step(); step();
        rst_n = 1'b0; req.valid = 1'b0;
        step();
        rst_n = 1'b1;
        m_buf_valid = 0;
        n_checks++; if (mem_req_addr !== 32'h0 || mem_req_valid !== 1'b0 || rsp.instr !== RESET_INSTR) begin n_fail++; $display("FAIL midreset_state: got valid=%b addr=%h instr=%h expected 0 0 %h", mem_req_valid, mem_req_addr, rsp.instr, RESET_INSTR); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp.ready) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midreset_stale_rsp: got %0d pulses expected 0", pulses); end
        model_fetch(32'h500, 0, 0, 0);
        do_fetch(32'h500, 0, 0, 0);
        n_checks++; if (nreq !== e_nreq || ins !== e_ins) begin n_fail++; $display("FAIL midreset_refetch: got %0d reqs %h expected %0d %h", nreq, ins, e_nreq, e_ins); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        req.valid = 1'b1; req.addr = 32'h0000_0203;
        for (int i = 0; i < 6; i++) begin
            step();
            seen[i] = rsp.ready;
        end
        req.valid = 1'b0;
        step(); step();
        n_checks++; if (seen !== 6'b010101) begin n_fail++; $display("FAIL back_to_back_pattern: got %b expected 010101", seen); end
    endtask

    task automatic test_random();
        logic [31:0] pool [4];
        logic [31:0] a;
        int          st, rl;
        bit          er;
        pool = '{32'h100, 32'h104, 32'h200, 32'h3F0};
        for (int t = 0; t < 40; t++) begin
            a = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            st = $urandom_range(0, 3);
            rl = $urandom_range(0, 3);
            er = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) begin
                fencei = 1'b1; step(); fencei = 1'b0;
                m_buf_valid = 0;
            end
            model_fetch(a, st, rl, er);
            do_fetch(a, st, rl, er);
            n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL rand%0d_latency addr=%h: got %0d expected %0d", t, a, lat, e_lat); end
            n_checks++; if (ins !== e_ins || ill !== e_ill) begin n_fail++; $display("FAIL rand%0d_rsp addr=%h: got %h ill=%b expected %h ill=%b", t, a, ins, ill, e_ins, e_ill); end
            n_checks++; if (nreq !== e_nreq) begin n_fail++; $display("FAIL rand%0d_bus addr=%h: got %0d reqs expected %0d", t, a, nreq, e_nreq); end
            if (e_nreq == 1) begin
                n_checks++; if (raddr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL rand%0d_bus_addr: got %h expected %h", t, raddr, {a[31:2], 2'b00}); end
            end
            n_checks++; if (rdy_a !== 1'b0 || ins_a !== RESET_INSTR) begin n_fail++; $display("FAIL rand%0d_after: got ready=%b instr=%h expected 0 %h", t, rdy_a, ins_a, RESET_INSTR); end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        req           = '0;
        fencei        = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        test_reset();
        test_misaligned();
        test_aligned_miss();
        test_buffer();
        test_spurious();
        test_backpressure();
        test_abort();
        test_bus_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
